// File: rtl/i2s_tx_serializer.sv
// I2S master-transmit serializer.
// Follows the upstream ws-generator slot state and pops one FIFO word per slot.
// Each word is shifted out MSB-first on sd; all state changes on the falling SCK edge.
// The one-edge lag behind the generator gives the Philips one-bit data delay.
// ws_state_i encoding: 2'd0 = IDLE, 2'd1 = L, 2'd2 = R.
module i2s_tx_serializer #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        ws_state_i,
    input  logic              frame32_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_empty_i,
    output logic              tx_rd_o,
    output logic              sd_o,
    output logic              busy_o,
    output logic              underrun_o
);

    localparam logic [1:0] WS_IDLE = 2'd0;

    logic [31:0] shreg_q, shreg_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic        busy_q, busy_d;
    logic        frame32_q, frame32_d;
    logic        tx_rd_q, tx_rd_d;
    logic        underrun_q, underrun_d;

    logic [4:0]  last;
    logic        slot_start;
    logic [31:0] word_aligned;

    // The slot length is latched at slot start, so mid-slot frame32 changes are ignored.
    assign last       = frame32_q ? 5'd31 : 5'd15;
    // A new slot begins when idle, or back-to-back right after the last bit of the previous slot.
    assign slot_start = (ws_state_i != WS_IDLE) && (!busy_q || bitcnt_q == last);
    // Left-align the word in the 32-bit slot; unused LSB positions shift out as 0.
    assign word_aligned = 32'(tx_data_i) << (32 - DATA_W);

    // Next-state: new slot load, shift, or end-of-slot idle, in that priority.
    always_comb begin
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        busy_d     = busy_q;
        frame32_d  = frame32_q;
        tx_rd_d    = 1'b0;
        underrun_d = 1'b0;
        if (slot_start) begin
            bitcnt_d  = 5'd0;
            busy_d    = 1'b1;
            frame32_d = frame32_i;
            if (!tx_empty_i) begin
                shreg_d = word_aligned;
                tx_rd_d = 1'b1;
            end else begin
                shreg_d    = 32'h0;
                underrun_d = 1'b1;
            end
        end else if (busy_q && bitcnt_q != last) begin
            shreg_d  = {shreg_q[30:0], 1'b0};
            bitcnt_d = bitcnt_q + 5'd1;
        end else if (busy_q) begin
            busy_d  = 1'b0;
            shreg_d = 32'h0;
        end
    end

    // Falling-edge state register; reset discards any partial word.
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            shreg_q    <= 32'h0;
            bitcnt_q   <= 5'd0;
            busy_q     <= 1'b0;
            frame32_q  <= 1'b1;
            tx_rd_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            busy_q     <= busy_d;
            frame32_q  <= frame32_d;
            tx_rd_q    <= tx_rd_d;
            underrun_q <= underrun_d;
        end
    end

    assign sd_o       = shreg_q[31];
    assign busy_o     = busy_q;
    assign tx_rd_o    = tx_rd_q;
    assign underrun_o = underrun_q;

endmodule
